// File: rtl/usb_rx_unstuff_decode.sv
// ---------------------------------------------------------------------------
// usb_rx_unstuff_decode
//
// Receive front end for a USB-style serial bus. It samples the dp/dm pair once
// per bit time (one clk), decodes NRZI into data bits and drops stuffed zeros.
// It also recognises end-of-packet (SE0 held for EOP_SE0_BITS bit times and
// then J) and flags stuffing violations, SE1 and SE0 runs that are too short.
// The decoded bit stream feeds the receive byte deserializer.
//
// Optional feature (compile-time macro USB_RX_SYNC_EN):
//   defined   : dp/dm each pass through a 2-flop synchronizer that resets to
//               J (dp=1, dm=0). Sample-to-output latency is 3 clks.
//   undefined : dp/dm feed the decoder directly. Latency is 1 clk.
//
// Parameters
//   STUFF_LEN     consecutive decoded 1s after which a stuffed 0 must follow
//   EOP_SE0_BITS  SE0 bit times required before the closing J
//
// Ports
//   clk        in   system clock, one bus bit time per cycle
//   rst_L      in   asynchronous active-low reset
//   dp, dm     in   bus D+ / D- samples
//   recving    in   receive path armed; low forces IDLE with no pulses
//   outb       out  decoded data bit, meaningful when out_valid=1
//   out_valid  out  outb carries a data bit this cycle
//   eop        out  one-cycle pulse on a valid end-of-packet
//   rx_err     out  one-cycle pulse on stuff violation, SE1 or short SE0
// ---------------------------------------------------------------------------
module usb_rx_unstuff_decode #(
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic clk,
  input  logic rst_L,
  input  logic dp,
  input  logic dm,
  input  logic recving,
  output logic outb,
  output logic out_valid,
  output logic eop,
  output logic rx_err
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int SW = $clog2(EOP_SE0_BITS + 1);
  localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
  localparam logic [SW-1:0] SE0_MIN   = SW'(EOP_SE0_BITS);
  localparam logic [SW-1:0] SE0_ONE   = SW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    SE0W = 2'd2,
    ERR  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Optional input synchronizer
  // ---------------------------------------------------------------------
  logic dp_s;
  logic dm_s;

`ifdef USB_RX_SYNC_EN
  logic [1:0] dp_sync;
  logic [1:0] dm_sync;

  // Reset value is the idle J state so no spurious K is seen after reset.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      dp_sync <= 2'b11;
      dm_sync <= 2'b00;
    end else begin
      dp_sync <= {dp_sync[0], dp};
      dm_sync <= {dm_sync[0], dm};
    end
  end

  assign dp_s = dp_sync[1];
  assign dm_s = dm_sync[1];
`else
  assign dp_s = dp;
  assign dm_s = dm;
`endif

  // ---------------------------------------------------------------------
  // Line decode
  // ---------------------------------------------------------------------
  logic is_jk;
  logic is_k;
  logic is_se0;
  logic is_se1;
  logic level;
  logic decoded;
  logic stuff_full;

  assign is_jk  = dp_s ^ dm_s;
  assign is_k   = ~dp_s & dm_s;
  assign is_se0 = ~dp_s & ~dm_s;
  assign is_se1 = dp_s & dm_s;
  assign level  = dp_s;                 // J=1, K=0

  // ---------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------
  state_t        state_reg,      state_next;
  logic [OW-1:0] ones_cnt_reg,   ones_cnt_next;
  logic [SW-1:0] se0_cnt_reg,    se0_cnt_next;
  logic          last_level_reg, last_level_next;
  logic          outb_reg,       outb_next;
  logic          out_valid_reg,  out_valid_next;
  logic          eop_reg,        eop_next;
  logic          rx_err_reg,     rx_err_next;

  // NRZI: no transition means a 1.
  assign decoded    = (level == last_level_reg);
  assign stuff_full = (ones_cnt_reg == STUFF_MAX);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_reg      <= IDLE;
      ones_cnt_reg   <= '0;
      se0_cnt_reg    <= '0;
      last_level_reg <= 1'b1;
      outb_reg       <= 1'b0;
      out_valid_reg  <= 1'b0;
      eop_reg        <= 1'b0;
      rx_err_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ones_cnt_reg   <= ones_cnt_next;
      se0_cnt_reg    <= se0_cnt_next;
      last_level_reg <= last_level_next;
      outb_reg       <= outb_next;
      out_valid_reg  <= out_valid_next;
      eop_reg        <= eop_next;
      rx_err_reg     <= rx_err_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    ones_cnt_next   = ones_cnt_reg;
    se0_cnt_next    = se0_cnt_reg;
    last_level_next = last_level_reg;

    if (!recving) begin
      // Abandon whatever was in flight; this also wins over a completing EOP.
      state_next      = IDLE;
      ones_cnt_next   = '0;
      se0_cnt_next    = '0;
      last_level_next = 1'b1;
    end else begin
      unique case (state_reg)
        IDLE: begin
          last_level_next = 1'b1;
          if (is_k) begin
            state_next      = RECV;
            last_level_next = 1'b0;
            ones_cnt_next   = '0;
            se0_cnt_next    = '0;
          end
        end

        RECV: begin
          if (is_jk) begin
            last_level_next = level;
            if (decoded) begin
              if (stuff_full) state_next = ERR;
              else            ones_cnt_next = ones_cnt_reg + 1'b1;
            end else begin
              // Either a stuffed zero or a real zero; both restart the run.
              ones_cnt_next = '0;
            end
          end else if (is_se0) begin
            state_next   = SE0W;
            se0_cnt_next = SE0_ONE;
          end else begin
            state_next = ERR;
          end
        end

        SE0W: begin
          if (is_se0) begin
            if (se0_cnt_reg < SE0_MIN) se0_cnt_next = se0_cnt_reg + 1'b1;
          end else if (!is_k && !is_se1 && (se0_cnt_reg >= SE0_MIN)) begin
            state_next      = IDLE;
            last_level_next = 1'b1;
            ones_cnt_next   = '0;
            se0_cnt_next    = '0;
          end else begin
            state_next = ERR;
          end
        end

        ERR: begin
          state_next = ERR;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output logic (values registered on the next edge)
  // ---------------------------------------------------------------------
  always_comb begin
    outb_next      = 1'b0;
    out_valid_next = 1'b0;
    eop_next       = 1'b0;
    rx_err_next    = 1'b0;

    if (recving) begin
      unique case (state_reg)
        IDLE: begin
          // The opening K is decoded against J and is always a data 0.
          if (is_k) out_valid_next = 1'b1;
        end

        RECV: begin
          if (is_jk) begin
            if (decoded) begin
              if (stuff_full) begin
                rx_err_next = 1'b1;
              end else begin
                out_valid_next = 1'b1;
                outb_next      = 1'b1;
              end
            end else if (!stuff_full) begin
              out_valid_next = 1'b1;
            end
          end else if (is_se1) begin
            rx_err_next = 1'b1;
          end
        end

        SE0W: begin
          if (!is_se0) begin
            if (!is_k && !is_se1 && (se0_cnt_reg >= SE0_MIN)) eop_next = 1'b1;
            else                                              rx_err_next = 1'b1;
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign outb      = outb_reg;
  assign out_valid = out_valid_reg;
  assign eop       = eop_reg;
  assign rx_err    = rx_err_reg;

endmodule
